// File: rtl/repeater_hub_pkg.sv
// Shared types and defaults for the single-port RGMII repeater.
package repeater_hub_pkg;

  typedef enum logic [1:0] {
    WAIT_IDLE = 2'd0,
    IDLE      = 2'd1,
    PASS      = 2'd2,
    JABBER    = 2'd3
  } gate_state_e;

  // 1522-byte frame at two nibbles per byte
  localparam int unsigned MAX_NIBBLES_DEF = 3044;

endpackage

// File: rtl/repeater_hub_delay_line.sv
// Fixed-depth shift register carrying {ctl, rxd} from the gate to the tx pins.
module hub_delay_line #(
  parameter int DEPTH = 2,
  parameter int W     = 5
) (
  input  logic         clk_i,
  input  logic         rst_n_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] stage_q [DEPTH];

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < DEPTH; i++) stage_q[i] <= '0;
    end else begin
      stage_q[0] <= d_i;
      for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign q_o = stage_q[DEPTH-1];

endmodule

// File: rtl/repeater_hub.sv
// Single-port RGMII repeater: input register, frame gate with jabber cut-off,
// fixed-latency delay line and saturating frame/jabber counters.
//
// state     | meaning
// WAIT_IDLE | after reset; blocked until a real idle sample is seen
// IDLE      | between frames; rx_ctl high starts a frame
// PASS      | forwarding nibbles and counting frame length
// JABBER    | frame overran MAX_NIBBLES; blocked until rx_ctl drops
module repeater_hub
  import repeater_hub_pkg::*;
#(
  parameter int          LATENCY     = 2,
  parameter int unsigned MAX_NIBBLES = MAX_NIBBLES_DEF,
  parameter int          CNT_W       = 16
) (
  input  logic             rgmii_rxc_1,
  input  logic             rst_n,
  input  logic [3:0]       rgmii_rxd_1,
  input  logic             rgmii_rx_ctl_1,
  output logic [3:0]       rgmii_txd_1,
  output logic             rgmii_txc_1,
  output logic             rgmii_tx_ctl_1,
  output logic [CNT_W-1:0] frame_count,
  output logic [CNT_W-1:0] jabber_count
);

  localparam int NIB_W = $clog2(MAX_NIBBLES + 1);

  logic             rx_ctl_q;
  logic [3:0]       rxd_q;
  logic             smp_vld_q;
  gate_state_e      state_q, state_d;
  logic [NIB_W-1:0] nib_cnt_q, nib_cnt_d;
  logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;
  logic [CNT_W-1:0] jabber_cnt_q, jabber_cnt_d;
  logic             fwd;
  logic [4:0]       gated;
  logic [4:0]       dly_out;

  // smp_vld_q keeps the cleared input register from passing for a real idle sample
  always_ff @(posedge rgmii_rxc_1 or negedge rst_n) begin
    if (!rst_n) begin
      rx_ctl_q     <= 1'b0;
      rxd_q        <= 4'h0;
      smp_vld_q    <= 1'b0;
      state_q      <= WAIT_IDLE;
      nib_cnt_q    <= '0;
      frame_cnt_q  <= '0;
      jabber_cnt_q <= '0;
    end else begin
      rx_ctl_q     <= rgmii_rx_ctl_1;
      rxd_q        <= rgmii_rxd_1;
      smp_vld_q    <= 1'b1;
      state_q      <= state_d;
      nib_cnt_q    <= nib_cnt_d;
      frame_cnt_q  <= frame_cnt_d;
      jabber_cnt_q <= jabber_cnt_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    nib_cnt_d    = nib_cnt_q;
    frame_cnt_d  = frame_cnt_q;
    jabber_cnt_d = jabber_cnt_q;
    fwd          = 1'b0;
    case (state_q)
      WAIT_IDLE: begin
        if (smp_vld_q && !rx_ctl_q) state_d = IDLE;
      end
      IDLE: begin
        if (rx_ctl_q) begin
          state_d   = PASS;
          nib_cnt_d = NIB_W'(1);
          fwd       = 1'b1;
        end
      end
      PASS: begin
        if (!rx_ctl_q) begin
          state_d = IDLE;
          if (frame_cnt_q != '1) frame_cnt_d = frame_cnt_q + 1'b1;
        end else if (nib_cnt_q >= NIB_W'(MAX_NIBBLES)) begin
          state_d = JABBER;
          if (jabber_cnt_q != '1) jabber_cnt_d = jabber_cnt_q + 1'b1;
        end else begin
          fwd       = 1'b1;
          nib_cnt_d = nib_cnt_q + 1'b1;
        end
      end
      JABBER: begin
        if (!rx_ctl_q) state_d = IDLE;
      end
      default: state_d = WAIT_IDLE;
    endcase
  end

  assign gated = {fwd, fwd ? rxd_q : 4'h0};

  hub_delay_line #(
    .DEPTH (LATENCY),
    .W     (5)
  ) u_dly (
    .clk_i   (rgmii_rxc_1),
    .rst_n_i (rst_n),
    .d_i     (gated),
    .q_o     (dly_out)
  );

  assign rgmii_tx_ctl_1 = dly_out[4];
  assign rgmii_txd_1    = dly_out[3:0];
  assign rgmii_txc_1    = rgmii_rxc_1;
  assign frame_count    = frame_cnt_q;
  assign jabber_count   = jabber_cnt_q;

endmodule

// File: tb/tb_repeater_hub.sv
// Directed bench for repeater_hub: per-cycle tx checks against hand-set
// forward flags delayed by the pipeline, plus counter and reset checks.
module tb_repeater_hub;

  localparam int MAXN = 3044;

  logic        clk;
  logic        rst_n;
  logic [3:0]  rxd;
  logic        rx_ctl;
  logic [3:0]  txd;
  logic        txc;
  logic        tx_ctl;
  logic [15:0] frame_count;
  logic [15:0] jabber_count;

  int n_checks = 0;
  int n_errors = 0;

  // expected {ctl, txd} for drives made 1, 2 and 3 negedges ago
  logic [4:0] sr0, sr1, sr2;

  repeater_hub #(
    .LATENCY     (2),
    .MAX_NIBBLES (MAXN),
    .CNT_W       (16)
  ) dut (
    .rgmii_rxc_1    (clk),
    .rst_n          (rst_n),
    .rgmii_rxd_1    (rxd),
    .rgmii_rx_ctl_1 (rx_ctl),
    .rgmii_txd_1    (txd),
    .rgmii_txc_1    (txc),
    .rgmii_tx_ctl_1 (tx_ctl),
    .frame_count    (frame_count),
    .jabber_count   (jabber_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic clr_sr();
    sr0 = '0; sr1 = '0; sr2 = '0;
  endtask

  // check outputs for the drive three negedges back, then drive one nibble
  task automatic cyc(input logic ctl, input logic [3:0] d, input logic fwd);
    @(negedge clk);
    check("tx_ctl", 32'(tx_ctl), 32'(sr2[4]));
    check("txd", 32'(txd), 32'(sr2[3:0]));
    sr2 = sr1;
    sr1 = sr0;
    sr0 = fwd ? {1'b1, d} : 5'h0;
    rx_ctl = ctl;
    rxd    = d;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 4'h0, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    clr_sr();
    repeat (2) @(negedge clk);
    check("rst_tx_ctl", 32'(tx_ctl), 0);
    check("rst_frames", 32'(frame_count), 0);
    check("rst_jabber", 32'(jabber_count), 0);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n  = 1'b0;
    rx_ctl = 1'b0;
    rxd    = 4'h0;
    clr_sr();

    // 1: reset held 100 ns while rxd steps
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      rxd = 4'(i);
      check("t1_rst_ctl", 32'(tx_ctl), 0);
      check("t1_rst_txd", 32'(txd), 0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) cyc(1'b0, 4'(i), 1'b0);
    check("t1_frames", 32'(frame_count), 0);
    check("t1_jabber", 32'(jabber_count), 0);
    @(negedge clk);
    check("t1_txc_lo", 32'(txc), 0);
    @(posedge clk);
    #1;
    check("t1_txc_hi", 32'(txc), 1);

    // 2: 8-nibble frame 1..8
    for (int i = 1; i <= 8; i++) cyc(1'b1, 4'(i), 1'b1);
    idle(5);
    check("t2_frames", 32'(frame_count), 1);

    // 3: reset released mid-frame
    @(negedge clk);
    rx_ctl = 1'b1;
    rxd    = 4'h5;
    rst_n  = 1'b0;
    clr_sr();
    repeat (2) @(negedge clk);
    check("t3_rst_frames", 32'(frame_count), 0);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) cyc(1'b1, 4'h5, 1'b0);
    idle(3);
    check("t3_tail_frames", 32'(frame_count), 0);
    for (int i = 9; i <= 12; i++) cyc(1'b1, 4'(i), 1'b1);
    idle(4);
    check("t3_frames", 32'(frame_count), 1);

    // 4: jabber
    do_reset();
    idle(2);
    for (int i = 0; i < MAXN + 10; i++) cyc(1'b1, 4'(i), (i < MAXN));
    idle(4);
    check("t4_jabber", 32'(jabber_count), 1);
    check("t4_frames", 32'(frame_count), 0);

    // 5: two frames with a one-cycle gap, then a one-nibble pulse
    for (int i = 1; i <= 4; i++) cyc(1'b1, 4'(i), 1'b1);
    idle(1);
    for (int i = 12; i <= 15; i++) cyc(1'b1, 4'(i), 1'b1);
    idle(4);
    check("t5_frames", 32'(frame_count), 2);
    cyc(1'b1, 4'h7, 1'b1);
    idle(4);
    check("t5_pulse_frames", 32'(frame_count), 3);
    check("t5_jabber", 32'(jabber_count), 1);

    // 6: async reset mid-frame
    for (int i = 0; i < 5; i++) cyc(1'b1, 4'h3, 1'b1);
    @(posedge clk);
    #2;
    check("t6_pre_ctl", 32'(tx_ctl), 1);
    check("t6_pre_txd", 32'(txd), 3);
    rst_n = 1'b0;
    #1;
    check("t6_ctl", 32'(tx_ctl), 0);
    check("t6_txd", 32'(txd), 0);
    check("t6_frames", 32'(frame_count), 0);
    check("t6_jabber", 32'(jabber_count), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
